// File: rtl/core_pkg.sv
// Shared core definitions: default register-file geometry and the register-index type.
package core_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

    localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects stored data and busy state for an index,
// applying the hardwired-zero register and same-cycle write forwarding.
module regfile_read_port
    import core_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic [AW-1:0]              rs,
    input  logic [NREG-1:0][XLEN-1:0]  regs,
    input  logic [NREG-1:0]            busy,
    input  logic                       we,
    input  logic [AW-1:0]              rd,
    input  logic [XLEN-1:0]            wd,
    output logic [XLEN-1:0]            data,
    output logic                       busy_o
);

    logic is_zero;
    logic fwd;

    // Forwarded data is by definition no longer outstanding, so busy reads 0 too.
    always_comb begin
        is_zero = (ZERO_REG != 0) && (rs == '0);
        fwd     = (BYPASS != 0) && we && (rd == rs) && !((ZERO_REG != 0) && (rd == '0));
        data    = regs[rs];
        busy_o  = busy[rs];
        if (is_zero) begin
            data   = '0;
            busy_o = 1'b0;
        end else if (fwd) begin
            data   = wd;
            busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with two async read ports, one sync write port and a
// per-register busy scoreboard for hazard detection between decode and writeback.
module regfile_scoreboard
    import core_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rd,
    input  logic            flush
);

    logic [NREG-1:0][XLEN-1:0] regs_q;
    logic [NREG-1:0][XLEN-1:0] regs_d;
    logic [NREG-1:0]           busy_q;
    logic [NREG-1:0]           busy_d;

    logic wr_ok;
    logic alloc_ok;

    always_comb begin
        wr_ok    = we && !((ZERO_REG != 0) && (rd == '0));
        alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_rd == '0));
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[rd] = wd;
        end
    end

    // Flush squashes all producers; otherwise a new allocation outranks the
    // writeback clear, so a same-register alloc+write leaves the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (we) begin
                busy_d[rd] = 1'b0;
            end
            if (alloc_ok) begin
                busy_d[alloc_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    regfile_read_port #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port1 (
        .rs     (rs1),
        .regs   (regs_q),
        .busy   (busy_q),
        .we     (we),
        .rd     (rd),
        .wd     (wd),
        .data   (rd1),
        .busy_o (rs1_busy)
    );

    regfile_read_port #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port2 (
        .rs     (rs2),
        .regs   (regs_q),
        .busy   (busy_q),
        .we     (we),
        .rd     (rd),
        .wd     (wd),
        .data   (rd2),
        .busy_o (rs2_busy)
    );

endmodule
